// File: rtl/mult_low_seq_if.sv
// Request/result bundle for the sequential shift-and-add multiplier.
// master drives operands and the start strobe; slave returns the product.
interface mult_low_seq_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic             data_rdy;
    logic [N-1:0]     mult1;
    logic [M-1:0]     mult2;
    logic             res_rdy;
    logic [N+M-1:0]   res;

    modport master (
        output data_rdy, mult1, mult2,
        input  res_rdy, res
    );

    modport slave (
        input  data_rdy, mult1, mult2,
        output res_rdy, res
    );
endinterface

// File: rtl/mult_low_seq.sv
// Unsigned N x M shift-and-add multiplier, one multiplier bit per clock.
// Optional MULT_LOW_EARLY_DONE_EN finishes once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for data_rdy; res holds the last product
// CALC  | one multiplier bit consumed per cycle, LSB first
// DONE  | res_rdy pulse, back to IDLE next edge
module mult_low_seq #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    mult_low_seq_if.slave  bus
);

    localparam int W  = N + M;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [W-1:0]    acc_q,     acc_d;
    logic [W-1:0]    mcand_q,   mcand_d;
    logic [M-1:0]    mplier_q,  mplier_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [W-1:0]    res_q,     res_d;
    logic            res_rdy_q, res_rdy_d;

    logic [W-1:0]    partial;
    logic            last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            res_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            res_rdy_q <= res_rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_rdy_d = 1'b0;

        partial = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MULT_LOW_EARLY_DONE_EN
        // Nothing left to add once the unconsumed multiplier bits are all zero.
        last_bit = (cnt_q == '0) || (mplier_q[M-1:1] == '0);
`else
        last_bit = (cnt_q == '0);
`endif

        case (state_q)
            IDLE: begin
                if (bus.data_rdy) begin
                    mcand_d  = {{M{1'b0}}, bus.mult1};
                    mplier_d = bus.mult2;
                    acc_d    = '0;
                    cnt_d    = CW'(M - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (last_bit) begin
                    res_d     = partial;
                    res_rdy_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.res     = res_q;
    assign bus.res_rdy = res_rdy_q;

endmodule

// File: tb/tb_mult_low_seq.sv
// Bench for mult_low_seq: edge-indexed product/latency model plus directed vectors.
module tb_mult_low_seq;
    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_low_seq_if #(.N(N), .M(M)) bus ();
    mult_low_seq #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Number of CALC cycles an operation with multiplier b takes.
    function automatic int lat_of(input int b);
        int hi;
        hi = 0;
        for (int i = 0; i < M; i++)
            if (((b >> i) & 1) == 1) hi = i + 1;
`ifdef MULT_LOW_EARLY_DONE_EN
        return (hi == 0) ? 1 : hi;
`else
        return (hi < 0) ? 0 : M;
`endif
    endfunction

    // Model: edge ecnt captures -> product visible and res_rdy high after edge ecnt+lat.
    int   ecnt   = 0;
    int   m_done = 0;
    int   m_prod = 0;
    int   m_res  = 0;
    logic m_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_res  <= 0;
        end else begin
            ecnt <= ecnt + 1;
            if (m_busy) begin
                if (ecnt == m_done)     m_res  <= m_prod;
                if (ecnt == m_done + 1) m_busy <= 1'b0;
            end else if (bus.data_rdy) begin
                m_busy <= 1'b1;
                m_prod <= int'(bus.mult1) * int'(bus.mult2);
                m_done <= ecnt + lat_of(int'(bus.mult2));
            end
        end
    end

    always @(negedge clk) begin
        chk("res_rdy", int'(bus.res_rdy), (m_busy && (ecnt - 1 == m_done)) ? 1 : 0);
        chk("res", int'(bus.res), m_res);
    end

    // Directed vectors with hand-computed products and CALC-cycle counts.
    int va[10] = '{3, 25, 16, 10, 15, 215, 13, 255, 0, 255};
    int vb[10] = '{2, 5, 10, 4, 7, 9, 5, 15, 15, 0};
    int vp[10] = '{6, 125, 160, 40, 105, 1935, 65, 3825, 0, 0};
`ifdef MULT_LOW_EARLY_DONE_EN
    int vl[10] = '{2, 3, 4, 3, 3, 4, 3, 4, 4, 1};
    localparam int LAT_200_11 = 4;
    localparam int LAT_6_7    = 3;
`else
    int vl[10] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    localparam int LAT_200_11 = 4;
    localparam int LAT_6_7    = 4;
`endif

    // Called at a negedge; returns at the negedge after the res_rdy pulse ends.
    task automatic run_op(input int a, input int b, input int exp_p, input int exp_l,
                          input bit disturb, input string name);
        int  k;
        bit  seen;
        bus.data_rdy = 1'b1;
        bus.mult1    = N'(a);
        bus.mult2    = M'(b);
        @(negedge clk);
        bus.data_rdy = disturb;
        bus.mult1    = disturb ? N'(7) : N'(~a);
        bus.mult2    = disturb ? M'(3) : M'(~b);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 2) bus.data_rdy = 1'b0;
            if (bus.res_rdy) seen = 1'b1;
        end
        if (!seen) begin
            chk({name, " timeout"}, 0, 1);
        end else begin
            chk({name, " latency"}, k, exp_l);
            chk({name, " product"}, int'(bus.res), exp_p);
        end
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        bus.data_rdy = 1'b0;
        bus.mult1    = '0;
        bus.mult2    = '0;
        repeat (4) begin
            @(negedge clk);
            bus.data_rdy = 1'b1;
            bus.mult1    = N'($urandom);
            bus.mult2    = M'($urandom);
        end
        @(negedge clk);
        chk("reset res", int'(bus.res), 0);
        chk("reset res_rdy", int'(bus.res_rdy), 0);
        rst          = 1'b0;
        bus.data_rdy = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(va[i], vb[i], vp[i], vl[i], 1'b0, $sformatf("vec%0d", i));

        run_op(200, 11, 2200, LAT_200_11, 1'b1, "busy");
        repeat (6) @(negedge clk);
        chk("res hold", int'(bus.res), 2200);

        bus.data_rdy = 1'b1;
        bus.mult1    = N'(9);
        bus.mult2    = M'(9);
        @(negedge clk);
        bus.data_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort res", int'(bus.res), 0);
        chk("abort res_rdy", int'(bus.res_rdy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post-abort res", int'(bus.res), 0);
        run_op(6, 7, 42, LAT_6_7, 1'b0, "post-abort");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
